// File: rtl/scan_display_mux_if.sv
// Display bus between the result formatter and the multiplexed 7-segment driver.
//   master: drives ena, in, dp_in, lz_en and bright; observes out, dp, sel and frame
//   slave : the scan driver; consumes the request side and drives the pin side
interface scan_display_mux_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BW     = 4
);
  // Request side: data to show and display controls
  logic                  ena;
  logic [4*DIGITS-1:0]   in;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_en;
  logic [BW-1:0]         bright;

  // Pin side: hex nibble, decimal point, active-low digit selects, frame strobe
  logic [3:0]            out;
  logic                  dp;
  logic [DIGITS-1:0]     sel;
  logic                  frame;

  modport master (
    output ena, in, dp_in, lz_en, bright,
    input  out, dp, sel, frame
  );

  modport slave (
    input  ena, in, dp_in, lz_en, bright,
    output out, dp, sel, frame
  );
endinterface

// File: rtl/scan_display_mux.sv
// Time-multiplexed driver for common-anode multi-digit 7-segment displays.
// Scans DIGITS nibbles, one per slot of PRESCALE clocks, with anti-ghost blanking
// at the start of each slot, PWM brightness, leading-zero suppression, decimal
// points and a frame-aligned shadow copy of the input so a frame never tears.
//   clk0       system clock
//   rst        asynchronous reset, active low
//   bus.ena    display enable; low forces every select inactive
//   bus.in     packed nibbles, digit k = in[4k+3:4k], digit 0 rightmost
//   bus.dp_in  decimal point request per digit
//   bus.lz_en  leading-zero suppression enable
//   bus.bright last slot count that may be lit (PWM threshold)
//   bus.out    nibble of the active digit, 4'hF when dark
//   bus.dp     decimal point of the active digit, active high
//   bus.sel    digit selects, active low, at most one low
//   bus.frame  one-cycle pulse at the end of each full scan
module scan_display_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned BLANK    = 2,
  parameter int unsigned BW       = $clog2(PRESCALE)
) (
  input  logic                clk0,
  input  logic                rst,
  scan_display_mux_if.slave   bus
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NW = 4 * DIGITS;

  // Scan position
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     dig;

  // Frame-aligned copy of the displayed data
  logic [NW-1:0]     sh_in;
  logic [DIGITS-1:0] sh_dp;

  // Combinational decode
  logic              slot_end_c;
  logic              frame_end_c;
  logic [CW-1:0]     cnt_nxt_c;
  logic [DW-1:0]     dig_nxt_c;
  logic [DIGITS-1:0] blanked_c;
  logic              keep_c;
  logic [3:0]        cur_nib_c;
  logic              cur_dp_c;
  logic              cur_blank_c;
  logic [DIGITS-1:0] cur_sel_c;
  logic              lit_c;

  // Scan counters: cnt wraps every slot, dig advances on each cnt wrap
  always_comb begin
    slot_end_c  = (cnt == CW'(PRESCALE - 1));
    frame_end_c = slot_end_c && (dig == DW'(DIGITS - 1));
    cnt_nxt_c   = cnt + CW'(1);
    dig_nxt_c   = dig;
    if (slot_end_c) begin
      if (dig == DW'(DIGITS - 1)) begin
        dig_nxt_c = '0;
      end else begin
        dig_nxt_c = dig + DW'(1);
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      dig <= '0;
    end else begin
      cnt <= cnt_nxt_c;
      dig <= dig_nxt_c;
    end
  end

  // Shadow load on the last clock of a frame so the next frame is coherent
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      sh_in <= '0;
      sh_dp <= '0;
    end else if (frame_end_c) begin
      sh_in <= bus.in;
      sh_dp <= bus.dp_in;
    end
  end

  // Leading-zero mask: walk from the leftmost digit down; once a non-zero
  // nibble or a requested decimal point is seen, that digit and all digits to
  // its right are kept. Digit 0 always stays visible.
  always_comb begin
    keep_c    = 1'b0;
    blanked_c = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      keep_c = keep_c | (sh_in[4*k +: 4] != 4'h0) | sh_dp[k];
      if (k != 0) begin
        blanked_c[k] = bus.lz_en & ~keep_c;
      end
    end
  end

  // Data, decimal point, blank flag and select pattern of the current digit
  always_comb begin
    cur_nib_c   = 4'h0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    cur_sel_c   = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (dig == DW'(k)) begin
        cur_nib_c    = sh_in[4*k +: 4];
        cur_dp_c     = sh_dp[k];
        cur_blank_c  = blanked_c[k];
        cur_sel_c[k] = 1'b0;
      end
    end
  end

  // Lit window: after the anti-ghost gap and up to the brightness threshold
  always_comb begin
    lit_c = bus.ena
          & (cnt >= CW'(BLANK))
          & (cnt <= bus.bright)
          & ~cur_blank_c;
  end

  // Registered pin outputs; reset drives the inactive pattern directly
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      bus.sel   <= '1;
      bus.out   <= 4'hF;
      bus.dp    <= 1'b0;
      bus.frame <= 1'b0;
    end else begin
      bus.frame <= frame_end_c;
      if (lit_c) begin
        bus.sel <= cur_sel_c;
        bus.out <= cur_nib_c;
        bus.dp  <= cur_dp_c;
      end else begin
        bus.sel <= '1;
        bus.out <= 4'hF;
        bus.dp  <= 1'b0;
      end
    end
  end

  // Never drive two digits at once
  a_one_cold: assert property (@(posedge clk0) disable iff (!rst)
    $countones(~bus.sel) <= 1);

endmodule

// File: doc/scan_display_mux.md
Name: scan_display_mux

Overview:
- Parametrised time-multiplexed driver for common-anode multi-digit 7-segment displays.
- Scans DIGITS nibble-wide digits from a packed input bus, one digit per slot of PRESCALE clocks.
- Adds anti-ghost blanking, PWM brightness, leading-zero suppression, decimal points and tear-free frame snapshots.
- Sits between the correlator result formatter and the board hex decoder / digit-select pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (2..8).
- PRESCALE, 16: clocks per digit slot, power of two, ≥4.
- BLANK, 2: clocks at the start of each slot with all selects forced inactive (anti-ghost); 1 ≤ BLANK < PRESCALE.
- BW, $clog2(PRESCALE): width of the brightness input.

Ports:
- clk0  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  display enable; low forces all selects inactive.
- in  in  4*DIGITS  packed nibbles; digit k = in[4k+3:4k], digit 0 rightmost.
- dp_in  in  DIGITS  decimal point request per digit.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  BW  brightness threshold.
- out  out  4  nibble for the active digit.
- dp  out  1  decimal point for the active digit, active-high.
- sel  out  DIGITS  digit selects, active-low, one-cold.
- frame  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Counters: cnt (0..PRESCALE-1) increments every clk0. On wrap, dig (0..DIGITS-1) increments; dig wraps to 0.
- Counters run regardless of ena.
- Shadow: sh_in and sh_dp load from in and dp_in when dig==DIGITS-1 and cnt==PRESCALE-1.
  - Displayed data changes only at frame boundaries; mid-frame input changes are never visible.
- Leading-zero mask, computed from the shadow data:
  - With lz_en=1, digit k is blanked if sh nibbles k..DIGITS-1 are all zero and k≠0. Digit 0 is never blanked.
  - A digit with its sh_dp bit set is never blanked, and neither is any digit below it.
  - With lz_en=0, no digit is blanked.
- Light condition for the current dig: ena & (cnt ≥ BLANK) & (cnt ≤ bright) & ~blanked[dig].
  - Consequences: bright < BLANK gives dark; bright = PRESCALE-1 gives maximum duty (PRESCALE-BLANK)/PRESCALE.
- Outputs are registered: the value for counter state (dig,cnt) appears one clk0 later.
  - sel: bit dig low when lit, all other bits high.
  - out: sh nibble of dig when lit, else 4'hF.
  - dp: sh_dp[dig] when lit, else 0.
  - frame: high for exactly one cycle, one clk0 after the shadow-load cycle.
- Reset (rst low, asynchronous):
  - cnt=0, dig=0, sh_in=0, sh_dp=0.
  - sel=all ones, out=4'hF, dp=0, frame=0.
  - The first frame after reset shows the zero shadow (digit 0 displays 0 when lz_en=1).
- Reset asserted mid-slot: outputs go inactive immediately, with no glitch on sel. After release, scanning restarts at digit 0, cnt 0.
- bright and lz_en are sampled combinationally each cycle; changes take effect on the next cycle.
- At most one sel bit is low in any cycle, under all inputs.

Test Plan:
(All with DIGITS=4, PRESCALE=8, BLANK=1.)
1. Reset release with in=16'h1234, bright=7, lz_en=0.
   - First frame: all digits show 0.
   - After the first frame pulse, digit 0 slot: sel=4'b1110, out=4 for cnt 1..7 (7 cycles); sel=4'b1111 at cnt 0.
   - Digit 3 shows 1.
2. bright=3.
   - Each digit lit for cnt 1..3 only (3 of 8 cycles).
   - bright=0: sel stays 4'b1111 for a whole frame.
3. lz_en=1, in=16'h0050.
   - Digits 3 and 2 are never selected.
   - Digit 1 shows 5 and digit 0 shows 0.
   - With in=16'h0000, only digit 0 lights, showing 0.
4. lz_en=1, in=16'h0007, dp_in=4'b0100.
   - Digit 2 lit with out=0, dp=1; digit 1 lit with out=0; digit 3 blanked.
5. in changes from 16'hAAAA to 16'h5555 mid-frame.
   - The current frame shows only A.
   - 5 appears only after the frame pulse; frame period is 32 cycles.
6. ena=0 for 10 cycles, then rst pulsed low mid-slot.
   - sel=4'b1111 throughout.
   - After release, the scan resumes at digit 0 with its first lit cycle at cnt=1 (output 2 clocks after release).
